mod5_serial_encoder: RTL and testbench
======================================

# mod5_serial_encoder

Serial transmitter for the mod-5 residue-coded bitstream consumed by the divisibility-by-5 checker. Accepts a DATA_W-bit parallel word over a valid/ready handshake and shifts it out MSB-first, one bit per transfer. It then appends a 3-bit check field so the whole (DATA_W+3)-bit frame, read as a binary number MSB-first, is an exact multiple of 5. It sits at the producer end of the link; the checker at the far end asserts its output on every frame boundary.

## Interface
- DATA_W, 8, payload width in bits (≥3)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_data  input  DATA_W  payload word
- in_valid  input  1  payload present
- in_ready  output  1  encoder can accept a word this cycle
- out_bit  output  1  current serial bit
- out_valid  output  1  out_bit is valid
- out_ready  input  1  downstream accepts out_bit this cycle
- out_last  output  1  out_bit is the final check bit of the frame

## Operation
- States: IDLE, DATA, CHECK.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data into the shift register, clear the residue to 0, enter DATA.
- DATA:
  - Present bits DATA_W-1 down to 0, one per beat. A beat is a cycle with out_valid&&out_ready.
  - Residue update per transferred bit b: r' = (2r + b) mod 5.
  - On the beat of bit 0, compute check c = (2·r_final) mod 5, load c as a 3-bit value, enter CHECK.
  - Check mapping: r=0→000, 1→010, 2→100, 3→001, 4→011.
- CHECK:
  - Present c[2], c[1], c[0]; out_last=1 on c[0].
  - On the c[0] beat, enter IDLE, or accept a new word directly (see back-to-back).
- Frame invariant: the stream value equals 8·data + c ≡ 0 (mod 5).
- Backpressure: while out_valid=1 and out_ready=0, out_bit, out_last and all state hold unchanged.
- Back-to-back:
  - in_ready is also 1 during CHECK while presenting c[0] with out_ready=1.
  - A word accepted then starts DATA on the next cycle, with no idle gap.
- in_ready=0 in DATA and in all other CHECK beats.
- in_data is ignored when in_ready=0.

## Timing
- Reset values: out_bit=0, out_valid=0, out_last=0, state=IDLE, residue=0.
- in_ready is decoded from state, so it reads 1 during and after reset.
- Reset asserted mid-frame aborts the frame immediately (asynchronous): out_valid drops in the same instant, the partial frame is discarded, and no check bits are sent.
- Latency: word accepted at edge T → out_valid=1 with the data MSB after edge T, i.e. visible in cycle T+1.
- Frame length is exactly DATA_W+3 beats.
- With out_ready held at 1, a frame occupies DATA_W+3 consecutive cycles.
- out_bit, out_valid and out_last are registered outputs. in_ready is combinational from state and out_ready only; there is no in_valid→in_ready path.

## Configuration
- MOD5_ENC_SELFCHECK_EN defined:
  - Adds output port err (1 bit, reset 0).
  - An independent second residue tracker follows every transferred bit of the frame, including the check bits.
  - If the residue is nonzero after the out_last beat, err sets and stays sticky until reset.
- Undefined: no err port and no checker logic. Functional behaviour is otherwise identical.

## Structure
- Package mod5_pkg holds:
  - the state enum (IDLE/DATA/CHECK);
  - residue typedef (3-bit logic);
  - constant MOD5_CHECK_W=3;
  - function mod5_check(r) implementing the mapping above.
- Sub-module mod5_residue_step: combinational (r, b) → (2r+b) mod 5.
  - Instantiated once for the main tracker.
  - Instantiated a second time under MOD5_ENC_SELFCHECK_EN.

## Test plan
All scenarios use DATA_W=8.
- Word 0x05, out_ready=1 → stream 00000101_000 (value 40), out_last on beat 11, in_ready back to 1 on that beat.
- Words 0x01 / 0x02 / 0x03 → check fields 010 / 100 / 001 (frame values 10, 20, 25).
- Word 0xFF (residue 0) → check 000.
- Word 0x04 → check 011.
- Back-to-back 0x03 then 0x01 with in_valid held high → 22 consecutive valid beats with no gap; out_last on beats 11 and 22.
- Random out_ready deasserts during word 0xA7 → out_bit/out_last stable while stalled; the reassembled frame ≡ 0 mod 5 and matches the unstalled sequence.
- Reset pulsed on beat 5 of a frame → out_valid=0 immediately, in_ready=1 after release; the next word 0x02 yields a clean frame ending 100. With MOD5_ENC_SELFCHECK_EN defined, err stays 0 in all of the above.

Source files
------------

// File: rtl/mod5_pkg.sv
// Shared types and helpers for the mod-5 residue-coded serial link.
package mod5_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } state_t;

  typedef logic [2:0] residue_t;

  localparam int MOD5_CHECK_W = 3;

  // Check field c = (2*r) mod 5 makes 8*data + c a multiple of 5.
  function automatic logic [MOD5_CHECK_W-1:0] mod5_check(input residue_t r);
    logic [MOD5_CHECK_W-1:0] c;
    case (r)
      3'd0:    c = 3'b000;
      3'd1:    c = 3'b010;
      3'd2:    c = 3'b100;
      3'd3:    c = 3'b001;
      3'd4:    c = 3'b011;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mod5_residue_step.sv
// One MSB-first residue update: r' = (2r + b) mod 5.
module mod5_residue_step
  import mod5_pkg::*;
(
  input  residue_t r,
  input  logic     b,
  output residue_t r_next
);

  logic [3:0] v_s;

  always_comb begin
    v_s = {r, b};
    if (v_s >= 4'd5) begin
      r_next = 3'(v_s - 4'd5);
    end else begin
      r_next = v_s[2:0];
    end
  end

endmodule

// File: rtl/mod5_serial_encoder.sv
// MSB-first serial encoder appending a 3-bit mod-5 check field per frame.
// Optional MOD5_ENC_SELFCHECK_EN adds a sticky err output from an independent residue tracker.
module mod5_serial_encoder
  import mod5_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef MOD5_ENC_SELFCHECK_EN
  output logic              err,
`endif
  output logic              out_last
);

  localparam int CNT_W = $clog2(DATA_W);

  state_t                  state_q, state_d;
  logic [DATA_W-1:0]       shift_q, shift_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  residue_t                res_q, res_d;
  residue_t                res_next_s;
  logic [MOD5_CHECK_W-1:0] chk_q, chk_d;
  logic [MOD5_CHECK_W-1:0] chk_new_s;
  logic                    out_bit_q, out_bit_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_last_q, out_last_d;
  logic                    beat_s;
  logic                    accept_s;

  assign out_bit   = out_bit_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  assign beat_s   = out_valid_q && out_ready;
  assign in_ready = (state_q == IDLE) ||
                    ((state_q == CHECK) && (cnt_q == CNT_W'(0)) && out_ready);
  assign accept_s = in_valid && in_ready;

  mod5_residue_step u_step (
    .r      (res_q),
    .b      (out_bit_q),
    .r_next (res_next_s)
  );

  assign chk_new_s = mod5_check(res_next_s);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    chk_d       = chk_q;
    out_bit_d   = out_bit_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d     = DATA;
          shift_d     = {in_data[DATA_W-2:0], 1'b0};
          out_bit_d   = in_data[DATA_W-1];
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          res_d       = 3'd0;
          cnt_d       = CNT_W'(DATA_W - 1);
        end else begin
          out_valid_d = 1'b0;
        end
      end
      DATA: begin
        if (beat_s) begin
          res_d = res_next_s;
          if (cnt_q == CNT_W'(0)) begin
            state_d   = CHECK;
            chk_d     = chk_new_s;
            out_bit_d = chk_new_s[2];
            cnt_d     = CNT_W'(2);
          end else begin
            out_bit_d = shift_q[DATA_W-1];
            shift_d   = {shift_q[DATA_W-2:0], 1'b0};
            cnt_d     = cnt_q - CNT_W'(1);
          end
        end else begin
          state_d = DATA;
        end
      end
      CHECK: begin
        if (beat_s) begin
          case (cnt_q)
            CNT_W'(2): begin
              out_bit_d = chk_q[1];
              cnt_d     = CNT_W'(1);
            end
            CNT_W'(1): begin
              out_bit_d  = chk_q[0];
              out_last_d = 1'b1;
              cnt_d      = CNT_W'(0);
            end
            default: begin
              // Last check bit leaves now; a waiting word starts without a gap.
              if (accept_s) begin
                state_d     = DATA;
                shift_d     = {in_data[DATA_W-2:0], 1'b0};
                out_bit_d   = in_data[DATA_W-1];
                out_valid_d = 1'b1;
                out_last_d  = 1'b0;
                res_d       = 3'd0;
                cnt_d       = CNT_W'(DATA_W - 1);
              end else begin
                state_d     = IDLE;
                out_bit_d   = 1'b0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
              end
            end
          endcase
        end else begin
          state_d = CHECK;
        end
      end
      default: begin
        state_d     = IDLE;
        out_bit_d   = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        res_d       = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      res_q       <= 3'd0;
      chk_q       <= 3'd0;
      out_bit_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      chk_q       <= chk_d;
      out_bit_q   <= out_bit_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

`ifdef MOD5_ENC_SELFCHECK_EN
  residue_t sc_res_q, sc_res_d;
  residue_t sc_res_next_s;
  logic     err_q, err_d;

  assign err = err_q;

  mod5_residue_step u_selfcheck_step (
    .r      (sc_res_q),
    .b      (out_bit_q),
    .r_next (sc_res_next_s)
  );

  // Whole-frame residue, check bits included, must land on zero at out_last.
  always_comb begin
    sc_res_d = sc_res_q;
    err_d    = err_q;
    if (beat_s) begin
      if (out_last_q) begin
        sc_res_d = 3'd0;
        if (sc_res_next_s != 3'd0) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
      end else begin
        sc_res_d = sc_res_next_s;
      end
    end else begin
      sc_res_d = sc_res_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sc_res_q <= 3'd0;
      err_q    <= 1'b0;
    end else begin
      sc_res_q <= sc_res_d;
      err_q    <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_mod5_serial_encoder.sv
// Directed bench for mod5_serial_encoder with an arithmetic frame model and per-cycle compare.
module tb_mod5_serial_encoder;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              out_ready = 1'b1;
  logic              in_ready;
  logic              out_bit;
  logic              out_valid;
  logic              out_last;
`ifdef MOD5_ENC_SELFCHECK_EN
  logic              err;
`endif

  int vectors = 0;
  int fails   = 0;

  mod5_serial_encoder #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef MOD5_ENC_SELFCHECK_EN
    .err       (err),
`endif
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame value is the smallest 8*d + c (c in 0..4) divisible by 5.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int v;
    int c;
    v = int'(d) * 8;
    c = (5 - (v % 5)) % 5;
    return 11'(v + c);
  endfunction

  logic [1:0]  exp_q[$];
  int          frames = 0;
  int          beat_idx = 0;
  logic [10:0] asm_r = '0;
  logic [10:0] last_frame = '0;
  logic        prev_stall = 1'b0;
  logic        prev_bit = 1'b0;
  logic        prev_last = 1'b0;

  always @(negedge clk) begin : compare_p
    bit          was_empty;
    bit          is_beat;
    bit          exp_last;
    logic [1:0]  e;
    logic [10:0] f;
    if (reset) begin
      exp_q.delete();
      asm_r      = '0;
      beat_idx   = 0;
      prev_stall = 1'b0;
    end else begin
      exp_last = 1'b0;
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_bit", out_bit, prev_bit);
        chk("stall_last", out_last, prev_last);
      end
      was_empty = (exp_q.size() == 0);
      is_beat   = out_valid && out_ready;
      chk("out_valid", out_valid, !was_empty);
      if (is_beat && !was_empty) begin
        e = exp_q.pop_front();
        exp_last = e[0];
        chk("out_bit", out_bit, e[1]);
        chk("out_last", out_last, e[0]);
        asm_r = {asm_r[9:0], out_bit};
        beat_idx++;
        if (e[0]) begin
          last_frame = asm_r;
          asm_r      = '0;
          beat_idx   = 0;
          frames++;
        end
      end
      chk("in_ready", in_ready, was_empty || (is_beat && exp_last));
`ifdef MOD5_ENC_SELFCHECK_EN
      chk("err", err, 0);
`endif
      prev_stall = out_valid && !out_ready;
      prev_bit   = out_bit;
      prev_last  = out_last;
      if (in_valid && in_ready) begin
        f = model_frame(in_data);
        for (int i = 10; i >= 0; i--) exp_q.push_back({f[i], (i == 0)});
      end
    end
  end

  task automatic send_word(input logic [7:0] d);
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    for (int k = 0; k < 200 && frames < target; k++) @(posedge clk);
    #1;
    chk("frame_done", frames, target);
  endtask

  task automatic run_word(input logic [7:0] d, input logic [10:0] exp_val);
    int start;
    start = frames;
    send_word(d);
    wait_frames(start + 1);
    chk("frame_value", last_frame, exp_val);
  endtask

  initial begin : stim_p
    int          start;
    logic [15:0] pat;
    pat = 16'b1101_0010_1110_0110;

    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bit", out_bit, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("model_05", model_frame(8'h05), 40);
    chk("model_04", model_frame(8'h04), 35);
    chk("model_a7", model_frame(8'hA7), 1340);

    run_word(8'h05, 11'd40);
    run_word(8'h01, 11'd10);
    run_word(8'h02, 11'd20);
    run_word(8'h03, 11'd25);
    run_word(8'hFF, 11'd2040);
    run_word(8'h04, 11'd35);

    // Back-to-back frames with in_valid held high across the boundary.
    start    = frames;
    in_data  = 8'h03;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_data = 8'h01;
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      chk("b2b_valid", out_valid, 1);
      chk("b2b_last", out_last, (k == 10) || (k == 21));
      if (k == 11) in_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("b2b_frames", frames, start + 2);
    chk("b2b_second", last_frame, 11'd10);

    // Backpressure pattern during 0xA7.
    start = frames;
    send_word(8'hA7);
    for (int k = 0; k < 200 && frames == start; k++) begin
      out_ready = pat[k % 16];
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    chk("stall_frames", frames, start + 1);
    chk("stall_value", last_frame, 11'd1340);
    chk("stall_mod5", 32'(last_frame % 11'd5), 0);

    // Reset in the middle of a frame.
    start = frames;
    send_word(8'hA7);
    for (int k = 0; k < 50 && beat_idx < 5; k++) @(negedge clk);
    chk("rst_beat_reached", beat_idx, 5);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("postrst_in_ready", in_ready, 1);
    chk("postrst_no_frame", frames, start);
    run_word(8'h02, 11'd20);
    chk("postrst_check", 32'(last_frame[2:0]), 32'd4);

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
